// File: rtl/mips_issue_sequencer_pkg.sv
// Shared types and constants for the Mini-MIPS issue sequencer and its decoders.
// Holds the FSM state and class enums, opcode field positions and the halt word.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEMW,
    ST_COMMIT,
    ST_HALTED
  } state_e;

  // One-hot so the class can drive the execute enables directly.
  typedef enum logic [4:0] {
    CLS_NONE   = 5'b00000,
    CLS_ALU    = 5'b00001,
    CLS_BRANCH = 5'b00010,
    CLS_FLOAT  = 5'b00100,
    CLS_JUMP   = 5'b01000,
    CLS_MEM    = 5'b10000
  } class_e;

  localparam int OP_F_HI = 31;
  localparam int OP_F_LO = 29;
  localparam int OP_S_HI = 28;
  localparam int OP_S_LO = 26;

  localparam logic [31:0] HALT_INSTR     = 32'hFFFF_FFFF;
  localparam logic [2:0]  SPLIT_ALU_JUMP = 3'b011;
  localparam logic [2:0]  SPLIT_JUMP_MEM = 3'b101;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mips_issue_sequencer_if.sv
// Bundle of fetch, data-memory, branch/jump and status signals around the sequencer.
// master = sequencer side, slave = memories, execution units and control.
interface mips_issue_sequencer_if;
  logic        start;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        en_alu;
  logic        en_branch;
  logic        en_float;
  logic        en_jump;
  logic        en_mem;
  logic        dmem_req;
  logic        dmem_ack;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] jmp_target;
  logic [31:0] pc;
  logic [31:0] retired;
  logic        busy;
  logic        halted;

  modport master (
    input  start, imem_ack, imem_rdata, dmem_ack, br_taken, br_target, jmp_target,
    output imem_req, imem_addr, instr, en_alu, en_branch, en_float, en_jump, en_mem,
           dmem_req, pc, retired, busy, halted
  );

  modport slave (
    output start, imem_ack, imem_rdata, dmem_ack, br_taken, br_target, jmp_target,
    input  imem_req, imem_addr, instr, en_alu, en_branch, en_float, en_jump, en_mem,
           dmem_req, pc, retired, busy, halted
  );
endinterface

// File: rtl/mips_issue_sequencer_decode.sv
// Combinational instruction classifier: one-hot execution class plus halt flag.
// The halt flag is independent of the class; callers give it priority.
module instr_class_decode
  import mips_ctrl_pkg::*;
(
  input  logic [31:0] word_i,
  output class_e      cls_o,
  output logic        halt_o
);

  logic [2:0] f;
  logic [2:0] s;

  always_comb begin
    f      = word_i[OP_F_HI:OP_F_LO];
    s      = word_i[OP_S_HI:OP_S_LO];
    halt_o = (word_i == HALT_INSTR);
    cls_o  = CLS_NONE;
    if (f < SPLIT_ALU_JUMP) begin
      cls_o = CLS_ALU;
    end else if (f == SPLIT_ALU_JUMP) begin
      cls_o = (s < SPLIT_JUMP_MEM) ? CLS_JUMP : CLS_MEM;
    end else if (f[2:1] == 2'b10) begin
      cls_o = CLS_BRANCH;
    end else begin
      cls_o = CLS_FLOAT;
    end
  end

endmodule

// File: rtl/mips_issue_sequencer.sv
// Sequenced fetch/decode/execute/commit controller for the Mini-MIPS core.
// All outputs are registered; requests hold until their ack, reset drops them next edge.
module mips_issue_sequencer
  import mips_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ALU_LAT  = 1,
  parameter int          FPU_LAT  = 4
) (
  input logic                  clk,
  input logic                  rst,
  mips_issue_sequencer_if.master bus
);

  localparam logic [3:0] ALU_CNT = 4'(ALU_LAT - 1);
  localparam logic [3:0] FPU_CNT = 4'(FPU_LAT - 1);

  state_e      state_q;
  class_e      cls_q;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] instr_q;
  logic [31:0] retired_q;
  logic [3:0]  cnt_q;
  logic [4:0]  en_q;
  logic        imem_req_q;
  logic        dmem_req_q;
  logic        busy_q;
  logic        halted_q;
  logic        taken_q;
  logic [31:0] br_tgt_q;
  logic [31:0] jmp_tgt_q;

  class_e      dec_cls;
  logic        dec_halt;

  instr_class_decode u_decode (
    .word_i (instr_q),
    .cls_o  (dec_cls),
    .halt_o (dec_halt)
  );

  always_comb begin
    pc_d = pc_q + 32'd4;
    if (cls_q == CLS_BRANCH && taken_q) begin
      pc_d = br_tgt_q;
    end else if (cls_q == CLS_JUMP) begin
      pc_d = jmp_tgt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cls_q      <= CLS_NONE;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      retired_q  <= '0;
      cnt_q      <= '0;
      en_q       <= '0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
      taken_q    <= 1'b0;
      br_tgt_q   <= '0;
      jmp_tgt_q  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q    <= ST_FETCH;
            imem_req_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (bus.imem_ack) begin
            instr_q    <= bus.imem_rdata;
            imem_req_q <= 1'b0;
            state_q    <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (dec_halt) begin
            state_q  <= ST_HALTED;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
          end else begin
            state_q <= ST_EXEC;
            cls_q   <= dec_cls;
            en_q    <= dec_cls;
            cnt_q   <= (dec_cls == CLS_ALU)   ? ALU_CNT :
                       (dec_cls == CLS_FLOAT) ? FPU_CNT : 4'd0;
          end
        end
        ST_EXEC: begin
          if (cnt_q == 4'd0) begin
            // Branch outcome and targets are only guaranteed valid in this last cycle.
            taken_q   <= bus.br_taken;
            br_tgt_q  <= word_align(bus.br_target);
            jmp_tgt_q <= word_align(bus.jmp_target);
            if (cls_q == CLS_MEM) begin
              state_q    <= ST_MEMW;
              dmem_req_q <= 1'b1;
            end else begin
              state_q <= ST_COMMIT;
              en_q    <= '0;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_MEMW: begin
          if (bus.dmem_ack) begin
            dmem_req_q <= 1'b0;
            en_q       <= '0;
            state_q    <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          pc_q       <= pc_d;
          retired_q  <= retired_q + 32'd1;
          state_q    <= ST_FETCH;
          imem_req_q <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.imem_req  = imem_req_q;
  assign bus.imem_addr = pc_q;
  assign bus.instr     = instr_q;
  assign bus.en_alu    = en_q[0];
  assign bus.en_branch = en_q[1];
  assign bus.en_float  = en_q[2];
  assign bus.en_jump   = en_q[3];
  assign bus.en_mem    = en_q[4];
  assign bus.dmem_req  = dmem_req_q;
  assign bus.pc        = pc_q;
  assign bus.retired   = retired_q;
  assign bus.busy      = busy_q;
  assign bus.halted    = halted_q;

endmodule

// File: tb/tb_mips_issue_sequencer.sv
// Directed bench for mips_issue_sequencer with a commit-driven scoreboard.
module tb_mips_issue_sequencer;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ret;
    int          cls;
    int          en_cnt;
    int          dm_cnt;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  exp_t sb[$];

  int          cnt[5];
  int          dcnt;
  logic [31:0] prev_ret;
  logic [4:0]  ev;
  exp_t        e;
  int          others;

  mips_issue_sequencer_if bus ();

  mips_issue_sequencer #(
    .RESET_PC (32'h0000_0000),
    .ALU_LAT  (1),
    .FPU_LAT  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Monitor: accumulate enable/request cycles per instruction, score on each commit.
  always @(negedge clk) begin
    ev = {bus.en_mem, bus.en_jump, bus.en_float, bus.en_branch, bus.en_alu};
    if (bus.busy !== 1'b1) begin
      for (int i = 0; i < 5; i++) cnt[i] = 0;
      dcnt = 0;
    end else begin
      for (int i = 0; i < 5; i++) if (ev[i]) cnt[i]++;
      if (bus.dmem_req) dcnt++;
    end
    if (bus.retired === prev_ret + 32'd1) begin
      if (sb.size() == 0) begin
        check32("unexpected_commit", bus.retired, prev_ret);
      end else begin
        e = sb.pop_front();
        check32("commit_pc", bus.pc, e.pc);
        check32("commit_retired", bus.retired, e.ret);
        check32("commit_en_cycles", 32'(cnt[e.cls]), 32'(e.en_cnt));
        others = 0;
        for (int i = 0; i < 5; i++) if (i != e.cls) others += cnt[i];
        check32("commit_other_en_cycles", 32'(others), 32'd0);
        check32("commit_dmem_cycles", 32'(dcnt), 32'(e.dm_cnt));
      end
      for (int i = 0; i < 5; i++) cnt[i] = 0;
      dcnt = 0;
    end
    prev_ret = bus.retired;
  end

  task automatic push(input logic [31:0] pc, input logic [31:0] ret, input int cls,
                      input int en_cnt, input int dm_cnt);
    exp_t x;
    x.pc = pc; x.ret = ret; x.cls = cls; x.en_cnt = en_cnt; x.dm_cnt = dm_cnt;
    sb.push_back(x);
  endtask

  task automatic fetch(input logic [31:0] w, input int wt);
    for (int i = 0; i < 100 && !bus.imem_req; i++) @(negedge clk);
    check1("fetch_req_seen", bus.imem_req, 1'b1);
    repeat (wt) @(negedge clk);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = w;
    @(negedge clk);
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    check32("instr_latched", bus.instr, w);
  endtask

  task automatic serve_dmem(input int d);
    for (int i = 0; i < 100 && !bus.dmem_req; i++) @(negedge clk);
    check1("dmem_req_seen", bus.dmem_req, 1'b1);
    repeat (d) @(negedge clk);
    bus.dmem_ack = 1'b1;
    @(negedge clk);
    bus.dmem_ack = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    check32("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  // cls index: 0 alu, 1 branch, 2 float, 3 jump, 4 mem; dmd < 0 means no data access.
  task automatic run(input logic [31:0] w, input int wt, input int cls, input int en_cnt,
                     input int dmd, input logic [31:0] pc, input logic [31:0] ret);
    push(pc, ret, cls, en_cnt, (dmd < 0) ? 0 : dmd + 1);
    fetch(w, wt);
    if (dmd >= 0) serve_dmem(dmd);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n;
    total = 0; bad = 0; dcnt = 0; prev_ret = '0;
    for (int i = 0; i < 5; i++) cnt[i] = 0;
    bus.start = 1'b0; bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.dmem_ack = 1'b0;
    bus.br_taken = 1'b0; bus.br_target = '0; bus.jmp_target = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    check32("reset_pc", bus.pc, 32'h0);
    check32("reset_instr", bus.instr, 32'h0);
    check32("reset_retired", bus.retired, 32'h0);
    check1("reset_imem_req", bus.imem_req, 1'b0);
    check1("reset_dmem_req", bus.dmem_req, 1'b0);
    check32("reset_enables", 32'({bus.en_mem, bus.en_jump, bus.en_float, bus.en_branch, bus.en_alu}), 32'h0);
    check1("reset_busy", bus.busy, 1'b0);
    check1("reset_halted", bus.halted, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check1("idle_no_fetch", bus.imem_req, 1'b0);

    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check1("busy_after_start", bus.busy, 1'b1);

    // alu, zero-wait: the next fetch request appears 4 cycles after the ack.
    push(32'h4, 32'd1, 0, 1, 0);
    fetch(32'h0000_0000, 0);
    n = 1;
    while (!bus.imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check32("alu_fetch_gap", 32'(n), 32'd4);
    drain();

    run(32'hC000_0000, 2, 2, 4, -1, 32'h8, 32'd2);

    bus.br_taken = 1'b1; bus.br_target = 32'h0000_0103;
    run(32'h8000_0000, 0, 1, 1, -1, 32'h100, 32'd3);
    bus.br_taken = 1'b0; bus.br_target = 32'h0000_0F00;
    run(32'h8000_0000, 1, 1, 1, -1, 32'h104, 32'd4);

    bus.jmp_target = 32'hFFFF_FFFF;
    run(32'h6000_0000, 0, 3, 1, -1, 32'hFFFF_FFFC, 32'd5);
    bus.jmp_target = 32'h0;

    // mem with a 3-cycle delayed ack; pc wraps from FFFF_FFFC to 0.
    run(32'h7400_0000, 0, 4, 5, 3, 32'h0, 32'd6);

    // Reset mid-MEMW aborts the instruction without a commit.
    fetch(32'h7400_0000, 0);
    for (int i = 0; i < 100 && !bus.dmem_req; i++) @(negedge clk);
    check1("abort_dmem_req_seen", bus.dmem_req, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check1("rst_dmem_req", bus.dmem_req, 1'b0);
    check1("rst_en_mem", bus.en_mem, 1'b0);
    check32("rst_pc", bus.pc, 32'h0);
    check32("rst_retired", bus.retired, 32'h0);
    check1("rst_busy", bus.busy, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check1("rst_idle_no_fetch", bus.imem_req, 1'b0);

    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    run(32'h0000_0000, 0, 0, 1, -1, 32'h4, 32'd1);

    // Halt word has priority over its float encoding and freezes the block.
    fetch(32'hFFFF_FFFF, 0);
    repeat (3) @(negedge clk);
    check1("halt_halted", bus.halted, 1'b1);
    check1("halt_busy", bus.busy, 1'b0);
    check1("halt_en_float", bus.en_float, 1'b0);
    check32("halt_pc", bus.pc, 32'h4);
    check32("halt_retired", bus.retired, 32'd1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check1("halt_start_ignored", bus.halted, 1'b1);
    check1("halt_no_fetch", bus.imem_req, 1'b0);
    check32("final_scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
